psram_tester: RTL and testbench

- Self-checking PSRAM exerciser sitting directly upstream of the `memory` controller; it replaces ad-hoc write/read sequencing in `top`.
- On `start`, writes a 16-bit LFSR pattern across a configurable byte-address window, then reads the window back and compares.
- Reports done/pass, error count, first-failure details and pass count.
- Drives the controller's addr/read_strb/write_strb/data_in and consumes mem_ready/data_out.

---
 rtl/psram_pkg.sv | 31 +++
 rtl/psram_lfsr16.sv | 42 ++++
 rtl/psram_tester.sv | 241 ++++++++++++++++++++++++
 tb/tb_psram_tester.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// Shared types and helpers for the PSRAM exerciser: FSM states, LFSR taps and
// the one-step Galois LFSR function used for both pattern and pass-seed advance.
package psram_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ISSUE = 4'd1,
    WR_GUARD = 4'd2,
    WR_WAIT  = 4'd3,
    RD_ISSUE = 4'd4,
    RD_GUARD = 4'd5,
    RD_WAIT  = 4'd6,
    PASS_END = 4'd7,
    DONE     = 4'd8
  } tester_state_t;

  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam int          BYTES_PER_WORD = 2;

  // Right-shifting Galois step: feedback applied when the bit shifted out is 1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] sh;
    sh = v >> 1;
    if (v[0]) begin
      lfsr_step = sh ^ LFSR_TAPS;
    end else begin
      lfsr_step = sh;
    end
  endfunction

endpackage

// File: rtl/psram_lfsr16.sv
// Loadable 16-bit Galois LFSR holding the running test pattern.
// value_next exposes the next-cycle value so callers can register it alongside.
module psram_lfsr16
  import psram_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value,
  output logic [15:0] value_next
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = seed;
    end else if (step) begin
      value_d = lfsr_step(value_q);
    end else begin
      value_d = value_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value      = value_q;
  assign value_next = value_d;

endmodule

// File: rtl/psram_tester.sv
// Self-checking PSRAM exerciser: writes an LFSR pattern across a word window,
// reads it back through the controller handshake and records mismatches.
module psram_tester
  import psram_pkg::*;
#(
  parameter int          ADDR_W     = 24,
  parameter int          NUM_WORDS  = 256,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter bit          CONTINUOUS = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              read_strb,
  output logic              write_strb,
  output logic [15:0]       data_in,
  input  logic [15:0]       data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [15:0]       first_err_exp,
  output logic [15:0]       first_err_got,
  output logic [15:0]       pass_count
);

  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_INC  = ADDR_W'(BYTES_PER_WORD);

  tester_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [15:0]       pass_seed_q, pass_seed_d;
  logic [15:0]       data_in_q, data_in_d;
  logic              write_strb_q, write_strb_d;
  logic              read_strb_q, read_strb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [15:0]       err_count_q, err_count_d;
  logic              err_seen_q, err_seen_d;
  logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
  logic [15:0]       first_err_exp_q, first_err_exp_d;
  logic [15:0]       first_err_got_q, first_err_got_d;
  logic [15:0]       pass_count_q, pass_count_d;

  logic        lfsr_load_s;
  logic        lfsr_step_s;
  logic [15:0] lfsr_seed_s;
  logic [15:0] lfsr_val_s;
  logic [15:0] lfsr_next_s;
  logic        last_word_s;

  psram_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (lfsr_load_s),
    .step       (lfsr_step_s),
    .seed       (lfsr_seed_s),
    .value      (lfsr_val_s),
    .value_next (lfsr_next_s)
  );

  assign last_word_s = (word_cnt_q == LAST_WORD);

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    word_cnt_d       = word_cnt_q;
    pass_seed_d      = pass_seed_q;
    done_d           = done_q;
    pass_d           = pass_q;
    err_count_d      = err_count_q;
    err_seen_d       = err_seen_q;
    first_err_addr_d = first_err_addr_q;
    first_err_exp_d  = first_err_exp_q;
    first_err_got_d  = first_err_got_q;
    pass_count_d     = pass_count_q;
    lfsr_load_s      = 1'b0;
    lfsr_step_s      = 1'b0;
    lfsr_seed_s      = pass_seed_q;

    case (state_q)
      IDLE: begin
        if (start && mem_ready) begin
          addr_d           = '0;
          word_cnt_d       = '0;
          lfsr_load_s      = 1'b1;
          err_count_d      = 16'h0000;
          err_seen_d       = 1'b0;
          first_err_addr_d = '0;
          first_err_exp_d  = 16'h0000;
          first_err_got_d  = 16'h0000;
          state_d          = WR_ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      WR_ISSUE: state_d = WR_GUARD;
      WR_GUARD: state_d = WR_WAIT;
      WR_WAIT: begin
        if (mem_ready) begin
          if (last_word_s) begin
            addr_d      = '0;
            word_cnt_d  = '0;
            lfsr_load_s = 1'b1;
            state_d     = RD_ISSUE;
          end else begin
            addr_d      = addr_q + ADDR_INC;
            word_cnt_d  = word_cnt_q + CNT_W'(1);
            lfsr_step_s = 1'b1;
            state_d     = WR_ISSUE;
          end
        end else begin
          state_d = WR_WAIT;
        end
      end
      RD_ISSUE: state_d = RD_GUARD;
      RD_GUARD: state_d = RD_WAIT;
      RD_WAIT: begin
        if (mem_ready) begin
          if (data_out != lfsr_val_s) begin
            if (err_count_q != 16'hFFFF) begin
              err_count_d = err_count_q + 16'd1;
            end else begin
              err_count_d = err_count_q;
            end
            // First mismatch since start is kept; later passes only add to the count.
            if (!err_seen_q) begin
              err_seen_d       = 1'b1;
              first_err_addr_d = addr_q;
              first_err_exp_d  = lfsr_val_s;
              first_err_got_d  = data_out;
            end else begin
              err_seen_d = err_seen_q;
            end
          end else begin
            err_count_d = err_count_q;
          end
          lfsr_step_s = 1'b1;
          addr_d      = addr_q + ADDR_INC;
          word_cnt_d  = word_cnt_q + CNT_W'(1);
          state_d     = last_word_s ? PASS_END : RD_ISSUE;
        end else begin
          state_d = RD_WAIT;
        end
      end
      PASS_END: begin
        pass_count_d = pass_count_q + 16'd1;
        done_d       = 1'b1;
        pass_d       = (err_count_q == 16'h0000);
        pass_seed_d  = lfsr_step(pass_seed_q);
        if (CONTINUOUS) begin
          addr_d      = '0;
          word_cnt_d  = '0;
          lfsr_load_s = 1'b1;
          lfsr_seed_s = pass_seed_d;
          state_d     = WR_ISSUE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered handshake outputs are derived from the state being entered.
  always_comb begin
    write_strb_d = (state_d == WR_ISSUE);
    read_strb_d  = (state_d == RD_ISSUE);
    busy_d       = (state_d != IDLE) && (state_d != DONE);
    if (state_d == WR_ISSUE) begin
      data_in_d = lfsr_next_s;
    end else begin
      data_in_d = data_in_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      word_cnt_q       <= '0;
      pass_seed_q      <= SEED;
      data_in_q        <= 16'h0000;
      write_strb_q     <= 1'b0;
      read_strb_q      <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_count_q      <= 16'h0000;
      err_seen_q       <= 1'b0;
      first_err_addr_q <= '0;
      first_err_exp_q  <= 16'h0000;
      first_err_got_q  <= 16'h0000;
      pass_count_q     <= 16'h0000;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      word_cnt_q       <= word_cnt_d;
      pass_seed_q      <= pass_seed_d;
      data_in_q        <= data_in_d;
      write_strb_q     <= write_strb_d;
      read_strb_q      <= read_strb_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      err_count_q      <= err_count_d;
      err_seen_q       <= err_seen_d;
      first_err_addr_q <= first_err_addr_d;
      first_err_exp_q  <= first_err_exp_d;
      first_err_got_q  <= first_err_got_d;
      pass_count_q     <= pass_count_d;
    end
  end

  assign addr           = addr_q;
  assign write_strb     = write_strb_q;
  assign read_strb      = read_strb_q;
  assign data_in        = data_in_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;
  assign first_err_exp  = first_err_exp_q;
  assign first_err_got  = first_err_got_q;
  assign pass_count     = pass_count_q;

endmodule

// File: tb/tb_psram_tester.sv
// Directed bench: two testers (single-shot and continuous) each driving an ideal
// PSRAM model with optional per-word read corruption, plus a per-cycle strobe checker.
module tb_psram_tester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_model
    logic        start;
    logic        ready;
    logic [23:0] addr;
    logic        rs, ws;
    logic [15:0] din, dout;
    logic        busy, done, pass;
    logic [15:0] err_count, fe_exp, fe_got, pass_count;
    logic [23:0] fe_addr;
    logic [15:0] mem [8];
    logic [7:0]  cmask;
    logic [2:0]  lat_q;
    logic        rd_q;
    logic [2:0]  wa_q;
    logic        prev_strb;

    psram_tester #(.ADDR_W(24), .NUM_WORDS(4), .SEED(16'hACE1), .CONTINUOUS(g == 1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mem_ready(ready),
      .addr(addr), .read_strb(rs), .write_strb(ws), .data_in(din), .data_out(dout),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_err_addr(fe_addr), .first_err_exp(fe_exp), .first_err_got(fe_got),
      .pass_count(pass_count)
    );

    // Ideal PSRAM: ready drops the cycle after a strobe, returns after 5 busy cycles.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ready <= 1'b1;
        lat_q <= 3'd0;
        rd_q  <= 1'b0;
        wa_q  <= 3'd0;
        dout  <= 16'h0000;
      end else if (ready && (ws || rs)) begin
        ready <= 1'b0;
        lat_q <= 3'd5;
        rd_q  <= rs;
        wa_q  <= addr[3:1];
        if (ws) mem[addr[3:1]] <= din;
      end else if (lat_q != 3'd0) begin
        lat_q <= lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          ready <= 1'b1;
          if (rd_q) dout <= cmask[wa_q] ? 16'h0000 : mem[wa_q];
        end
      end
    end

    always @(posedge clk) prev_strb <= rst_n && (ws || rs);

    always @(negedge clk) begin
      if (rst_n) begin
        chk($sformatf("strb_excl%0d", g), {31'd0, ws && rs}, 32'd0);
        chk($sformatf("strb_ready%0d", g), {31'd0, (ws || rs) && !ready}, 32'd0);
        chk($sformatf("strb_b2b%0d", g), {31'd0, (ws || rs) && prev_strb}, 32'd0);
      end
    end
  end

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done0(input string tag);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!(gen_model[0].done && !gen_model[0].busy) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, {31'd0, gen_model[0].done && !gen_model[0].busy}, 32'd1);
  endtask

  task automatic wait_pc1(input logic [15:0] target);
    int n;
    n = 0;
    while (gen_model[1].pass_count != target && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_pass_count", {16'd0, gen_model[1].pass_count}, {16'd0, target});
  endtask

  initial begin
    int n;
    gen_model[0].start = 1'b0;
    gen_model[1].start = 1'b0;
    gen_model[0].cmask = 8'h00;
    gen_model[1].cmask = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", {8'd0, gen_model[0].addr}, 32'd0);
    chk("rst_strobes", {30'd0, gen_model[0].ws, gen_model[0].rs}, 32'd0);
    chk("rst_data_in", {16'd0, gen_model[0].din}, 32'd0);
    chk("rst_flags", {29'd0, gen_model[0].busy, gen_model[0].done, gen_model[0].pass}, 32'd0);
    chk("rst_err", {16'd0, gen_model[0].err_count}, 32'd0);
    chk("rst_first", {gen_model[0].fe_exp, gen_model[0].fe_got}, 32'd0);
    chk("rst_pass_count", {16'd0, gen_model[0].pass_count}, 32'd0);
    rst_n = 1'b1;

    // Clean pass: pattern ACE1, E270, 7138, 389C from the Galois step with taps B400.
    @(posedge clk); #1;
    gen_model[0].start = 1'b1;
    wait_done0("t1_wait");
    gen_model[0].start = 1'b0;
    chk("t1_mem0", {16'd0, gen_model[0].mem[0]}, 32'h0000ACE1);
    chk("t1_mem1", {16'd0, gen_model[0].mem[1]}, 32'h0000E270);
    chk("t1_mem2", {16'd0, gen_model[0].mem[2]}, 32'h00007138);
    chk("t1_mem3", {16'd0, gen_model[0].mem[3]}, 32'h0000389C);
    chk("t1_pass", {31'd0, gen_model[0].pass}, 32'd1);
    chk("t1_err", {16'd0, gen_model[0].err_count}, 32'd0);
    chk("t1_pass_count", {16'd0, gen_model[0].pass_count}, 32'd1);
    repeat (2) @(posedge clk); #1;
    chk("t1_idle_keep", {30'd0, gen_model[0].busy, gen_model[0].done}, 32'd1);

    // One corrupted word at byte address 4.
    pulse_reset();
    gen_model[0].cmask = 8'h04;
    gen_model[0].start = 1'b1;
    wait_done0("t2_wait");
    gen_model[0].start = 1'b0;
    chk("t2_err", {16'd0, gen_model[0].err_count}, 32'd1);
    chk("t2_fe_addr", {8'd0, gen_model[0].fe_addr}, 32'd4);
    chk("t2_fe_exp", {16'd0, gen_model[0].fe_exp}, 32'h00007138);
    chk("t2_fe_got", {16'd0, gen_model[0].fe_got}, 32'h00000000);
    chk("t2_pass", {31'd0, gen_model[0].pass}, 32'd0);

    // Two corrupted words at byte addresses 2 and 6.
    pulse_reset();
    gen_model[0].cmask = 8'h0A;
    gen_model[0].start = 1'b1;
    wait_done0("t3_wait");
    gen_model[0].start = 1'b0;
    chk("t3_err", {16'd0, gen_model[0].err_count}, 32'd2);
    chk("t3_fe_addr", {8'd0, gen_model[0].fe_addr}, 32'd2);
    chk("t3_fe_exp", {16'd0, gen_model[0].fe_exp}, 32'h0000E270);
    chk("t3_pass", {31'd0, gen_model[0].pass}, 32'd0);

    // Abort during a read wait, then a fresh clean pass.
    pulse_reset();
    gen_model[0].cmask = 8'h00;
    gen_model[0].start = 1'b1;
    n = 0;
    while (!gen_model[0].rs && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4_read_seen", {31'd0, gen_model[0].rs}, 32'd1);
    gen_model[0].start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_abort_flags", {29'd0, gen_model[0].busy, gen_model[0].ws, gen_model[0].rs}, 32'd0);
    chk("t4_abort_addr", {8'd0, gen_model[0].addr}, 32'd0);
    @(posedge clk); #1;
    chk("t4_abort_err", {gen_model[0].err_count, gen_model[0].pass_count}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    gen_model[0].start = 1'b1;
    wait_done0("t4_wait");
    gen_model[0].start = 1'b0;
    chk("t4_pass", {31'd0, gen_model[0].pass}, 32'd1);
    chk("t4_err", {16'd0, gen_model[0].err_count}, 32'd0);
    chk("t4_pass_count", {16'd0, gen_model[0].pass_count}, 32'd1);

    // Continuous mode: each pass restarts from the previous seed stepped once.
    pulse_reset();
    gen_model[1].start = 1'b1;
    wait_pc1(16'd1);
    gen_model[1].start = 1'b0;
    chk("c1_first_ws", {31'd0, gen_model[1].ws}, 32'd1);
    chk("c1_first_data", {16'd0, gen_model[1].din}, 32'h0000E270);
    chk("c1_first_addr", {8'd0, gen_model[1].addr}, 32'd0);
    wait_pc1(16'd2);
    chk("c2_first_data", {16'd0, gen_model[1].din}, 32'h00007138);
    wait_pc1(16'd3);
    chk("c3_busy", {31'd0, gen_model[1].busy}, 32'd1);
    chk("c3_done_pass", {30'd0, gen_model[1].done, gen_model[1].pass}, 32'd3);
    chk("c3_err", {16'd0, gen_model[1].err_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
